// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the PC / branch-prediction unit.
//   - Branch codes used on ex_branch (BR_*).
//   - 2-bit saturating-counter values (CNT_*).
//   - bht_entry_t: per-entry prediction state held by pc_bht.
// No ports. Optional feature macro used by the users of this package: PC_BHT_EN.
package pc_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_NE   = 3'b001;  // BNE/BLT/BLTU: taken when zero is clear
    localparam logic [2:0] BR_EQ   = 3'b010;  // BEQ/BGE/BGEU: taken when zero is set
    localparam logic [2:0] BR_JAL  = 3'b011;
    localparam logic [2:0] BR_JALR = 3'b100;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Tag and target widths depend on the XLEN/BHT_DEPTH of each instance, so pc_bht
    // keeps those two fields in parallel arrays indexed like the entry array.
    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_entry_t;

endpackage

// File: rtl/pc_bht.sv
// pc_bht: direct-mapped branch history / target table.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid bits only)
//   rd_idx, rd_tag  lookup index/tag of the fetch PC
//   rd_taken        hit and counter predicts taken
//   rd_target       stored target of the looked-up entry
//   wr_en           train this edge (resolved branch in EX)
//   wr_idx, wr_tag  index/tag of the resolved branch PC
//   wr_taken        resolved direction
//   wr_target       resolved target
// Only instantiated when PC_BHT_EN is defined.
module pc_bht
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    localparam int unsigned IDX_W    = $clog2(BHT_DEPTH),
    localparam int unsigned TAG_W    = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_taken,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);

    bht_entry_t       entry_q  [BHT_DEPTH];
    logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
    logic [XLEN-1:0]  target_q [BHT_DEPTH];

    bht_entry_t rd_entry, wr_entry;
    logic       rd_hit, wr_hit;
    logic [1:0] cnt_upd;

    // Lookup reads registered state, so a same-cycle write is seen only next cycle.
    assign rd_entry  = entry_q[rd_idx];
    assign rd_hit    = rd_entry.valid && (tag_q[rd_idx] == rd_tag);
    assign rd_taken  = rd_hit && rd_entry.cnt[1];
    assign rd_target = target_q[rd_idx];

    assign wr_entry = entry_q[wr_idx];
    assign wr_hit   = wr_entry.valid && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        cnt_upd = wr_entry.cnt;
        if (!wr_hit) begin
            cnt_upd = wr_taken ? CNT_WT : CNT_WNT;
        end else if (wr_taken) begin
            if (wr_entry.cnt != CNT_ST) cnt_upd = wr_entry.cnt + 2'd1;
        end else begin
            if (wr_entry.cnt != CNT_SNT) cnt_upd = wr_entry.cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= '{valid: 1'b1, cnt: cnt_upd};
        end
    end

    // Tag/target need no reset; a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            if (!wr_hit || wr_taken) target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with next-PC prediction and EX-stage branch resolution.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           hold the fetch PC (overridden by flush)
//   if_pc           registered fetch PC
//   if_pred_taken   prediction for if_pc
//   if_pred_target  predicted next PC for if_pc
//   ex_*            EX-stage instruction: valid, pc, branch code, zero flag, imm, ALU result,
//                   and the prediction it was fetched with
//   ex_link         ex_pc + 4
//   ex_taken        resolved direction
//   flush           mispredict: kill IF/ID, corrected PC loads on this edge
// Macro PC_BHT_EN: defined -> dynamic prediction via pc_bht; undefined -> static not-taken.
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    BHT_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_branch,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_aluout,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] ex_link,
    output logic            ex_taken,
    output logic            flush
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    if (BHT_DEPTH < 4 || (BHT_DEPTH & (BHT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BHT_DEPTH must be a power of two and at least 4");
    end

    logic [XLEN-1:0] pc_q, pc_plus4;
    logic [XLEN-1:0] br_target, actual_next;
    logic            taken, is_branch;

    assign pc_plus4 = pc_q + PC_STEP;
    assign if_pc    = pc_q;

    // Resolution
    always_comb begin
        taken     = 1'b0;
        br_target = ex_pc + ex_imm;
        case (ex_branch)
            BR_NE:   taken = ~ex_zero;
            BR_EQ:   taken = ex_zero;
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken     = 1'b1;
                br_target = ex_aluout & ~XLEN'(1);
            end
            default: taken = 1'b0;
        endcase
    end

    assign is_branch   = (ex_branch != BR_NONE);
    assign ex_link     = ex_pc + PC_STEP;
    assign ex_taken    = taken;
    assign actual_next = taken ? br_target : ex_link;
    assign flush       = ex_valid && is_branch &&
                         ((taken != ex_pred_taken) || (taken && (br_target != ex_pred_target)));

`ifdef PC_BHT_EN
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic            bht_taken;
    logic [XLEN-1:0] bht_target;

    pc_bht #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_q[IDX_W+1:2]),
        .rd_tag    (pc_q[XLEN-1:IDX_W+2]),
        .rd_taken  (bht_taken),
        .rd_target (bht_target),
        .wr_en     (ex_valid && is_branch),
        .wr_idx    (ex_pc[IDX_W+1:2]),
        .wr_tag    (ex_pc[XLEN-1:IDX_W+2]),
        .wr_taken  (taken),
        .wr_target (br_target)
    );

    assign if_pred_taken  = bht_taken;
    assign if_pred_target = bht_taken ? bht_target : pc_plus4;
`else
    // Static not-taken: every taken branch or jump resolves as a mispredict.
    assign if_pred_taken  = 1'b0;
    assign if_pred_target = pc_plus4;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= actual_next;
        end else if (stall) begin
            pc_q <= pc_q;
        end else if (if_pred_taken) begin
            pc_q <= if_pred_target;
        end else begin
            pc_q <= pc_plus4;
        end
    end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised program-counter unit with dynamic branch prediction.
- Fetch side: owns the fetch PC register and predicts the next PC from a direct-mapped branch history/target table (BHT).
- Execute side: resolves branches with the team's 3-bit branch encoding, trains the table, and raises a flush with the corrected PC on a mispredict.
- Sits between IF (drives the instruction-memory address) and EX (receives resolution inputs), replacing the combinational PC-select logic.

## Interface
- XLEN, 32, address/data width
- BHT_DEPTH, 64, table entries; power of two, minimum 4
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch PC (hazard unit)
- if_pc  out  XLEN  current fetch PC (registered)
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  XLEN  predicted next PC for if_pc
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  XLEN  PC of the EX instruction
- ex_branch  in  3  000 none, 001 BNE/BLT/BLTU, 010 BEQ/BGE/BGEU, 011 JAL, 100 JALR
- ex_zero  in  1  ALU zero flag
- ex_imm  in  XLEN  immediate
- ex_aluout  in  XLEN  ALU result (JALR target source)
- ex_pred_taken  in  1  if_pred_taken carried down the pipe
- ex_pred_target  in  XLEN  if_pred_target carried down the pipe
- ex_link  out  XLEN  ex_pc + 4
- ex_taken  out  1  resolved taken
- flush  out  1  mispredict; kill IF/ID

## Operation
- Resolution, combinational:
  - taken = (001 & ~zero) | (010 & zero) | 011 | 100.
  - Target = ex_pc + ex_imm for 001/010/011; (ex_aluout & ~1) for 100.
  - Actual next = taken ? target : ex_pc + 4.
- flush = ex_valid & (ex_branch != 000) & (taken != ex_pred_taken | (taken & target != ex_pred_target)).
- Non-branch EX instruction: flush = 0, ex_taken = 0. A non-branch with ex_pred_taken = 1 cannot occur; the table only allocates for branches.
- PC update priority, per edge:
  1. rst: RESET_PC.
  2. flush: actual next. Flush overrides stall.
  3. stall: hold.
  4. if_pred_taken: if_pred_target.
  5. Otherwise: if_pc + 4.
- All additions wrap modulo 2^XLEN.
- Table index = pc[log2(BHT_DEPTH)+1:2]; tag = pc[XLEN-1:log2(BHT_DEPTH)+2].
- Entry fields: valid, tag, 2-bit counter, target.
- Lookup: hit = valid & tag match. Hit: if_pred_taken = counter[1], if_pred_target = counter[1] ? target : if_pc+4. Miss: if_pred_taken = 0, if_pred_target = if_pc+4.
- Training, on ex_valid & ex_branch != 000, at the clock edge:
  - Hit: counter saturates up if taken, down if not; target overwritten when taken.
  - Miss: allocate; counter = taken ? 10 : 01; target = resolved target.
- Training is independent of stall. ex_valid gating is the caller's responsibility.

## Timing
- Reset values: if_pc = RESET_PC, all valid bits 0, if_pred_taken = 0, if_pred_target = RESET_PC+4, flush = 0, ex_taken = 0, ex_link = 4 (ex_pc = 0 under bench reset).
- Reset clears only valid bits; counters and targets are don't-care. Reset during a flush: reset wins, and no training occurs that edge.
- Prediction is combinational from the registered if_pc: zero-cycle lookup.
- Redirect penalty on mispredict: 1 cycle. The corrected PC appears on if_pc the edge after flush.
- Same-cycle read and write to the same index: the lookup sees the old entry; the new entry is visible next cycle.

## Configuration
- PC_BHT_EN defined: table and dynamic prediction as above.
- PC_BHT_EN undefined:
  - No table storage.
  - if_pred_taken is tied to 0 and if_pred_target to if_pc+4 (static not-taken).
  - Every taken branch or jump flushes.
  - BHT_DEPTH is ignored.

## Structure
- Package pc_pkg holds:
  - Branch codes BR_NONE, BR_NE, BR_EQ, BR_JAL, BR_JALR.
  - Counter constants CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11.
  - The bht_entry_t struct.
- Sub-module pc_bht: storage, lookup, and training. The top level holds the PC register, resolution, and flush.

## Test plan
- Reset with RESET_PC=0x100: if_pc=0x100, flush=0. Three free-running cycles give 0x104, 0x108, 0x10C.
- BEQ at 0x200, zero=1, imm=0x40, pred not-taken → flush=1, if_pc=0x240 next edge, entry allocated with counter 10. Refetch of 0x200 → if_pred_taken=1, target 0x240.
- Same BEQ resolved taken twice → counter 11. Then not-taken: flush=1, corrected PC 0x204, counter 10, still predicts taken.
- JALR with aluout=0x1235, pred target 0x1000 → flush=1, if_pc=0x1234 (LSB cleared).
- stall=1 together with flush=1 → if_pc takes the corrected target. stall=1 without flush → if_pc holds for the whole stall.
- Build without PC_BHT_EN: JAL at 0x300, imm=8 → flush every time, if_pc=0x308. if_pred_taken never asserts.
